// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Responder end of the core's data-memory port. Requests are accepted with a
//   one-cycle mem_valid strobe, held for a programmable number of wait cycles,
//   and then answered with a single-cycle mem_ready pulse. Backed by a
//   word-organised scratchpad with per-byte write enables. Requests that fall
//   outside the window [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4) are answered with
//   mem_error instead of touching the array.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 16)
//   LATENCY      extra wait cycles before the response (0..15)
//   BASE_ADDR    byte address of word 0, aligned to DEPTH_WORDS*4
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   mem_valid  in   request strobe, one cycle per request
//   mem_instr  in   1 = instruction fetch (always a read)
//   mem_addr   in   byte address, bits [1:0] ignored
//   mem_wdata  in   write data, byte lane i = bits [8i+7:8i]
//   mem_wstrb  in   byte write enables, 4'b0000 = read
//   mem_ready  out  one-cycle response pulse
//   mem_rdata  out  read data (post-write word on writes), 0 outside responses
//   mem_error  out  out-of-range flag, 0 outside responses
`timescale 1ns/1ps

module data_memory_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // WAIT is entered with count = LATENCY-1 and left when count reaches 0,
  // which gives exactly LATENCY cycles in WAIT.
  localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        count;

  // Request captured at acceptance, consumed when WAIT hands over to RESP.
  logic [IDX_W-1:0]  cap_index;
  logic              cap_in_range;
  logic [31:0]       cap_wdata;
  logic [3:0]        cap_wr_en;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [31:0]       req_off;
  logic              req_in_range;
  logic [IDX_W-1:0]  req_index;
  logic [3:0]        req_wr_en;
  logic              accept;
  logic              fire;
  logic [IDX_W-1:0]  acc_index;
  logic              acc_in_range;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_wr_en;
  logic [31:0]       old_word;
  logic [31:0]       merged_word;

  // Decode the live request. The offset subtraction wraps, so addresses below
  // BASE_ADDR land far above the window and are flagged out of range. A fetch
  // never writes, whatever the strobes say.
  always_comb begin
    req_off      = mem_addr - BASE_ADDR;
    req_in_range = ((req_off >> (IDX_W + 2)) == 32'd0);
    req_index    = req_off[IDX_W+1:2];
    req_wr_en    = mem_instr ? 4'b0000 : mem_wstrb;
  end

  // fire marks the edge that enters RESP; the array access happens on that
  // edge. With zero latency this is the acceptance edge itself, so the live
  // request is used; otherwise the request captured on entry to WAIT is used.
  // Gating with reset keeps an in-flight write from committing during reset.
  always_comb begin
    accept       = mem_valid && (state == S_IDLE || state == S_RESP);
    fire         = reset && (((LATENCY == 0) && accept) ||
                             (state == S_WAIT && count == 4'd0));
    acc_index    = (state == S_WAIT) ? cap_index    : req_index;
    acc_in_range = (state == S_WAIT) ? cap_in_range : req_in_range;
    acc_wdata    = (state == S_WAIT) ? cap_wdata    : mem_wdata;
    acc_wr_en    = (state == S_WAIT) ? cap_wr_en    : req_wr_en;
    old_word     = mem[acc_index];
    merged_word  = old_word;
    for (int i = 0; i < 4; i++) begin
      if (acc_wr_en[i]) merged_word[8*i +: 8] = acc_wdata[8*i +: 8];
    end
  end

  // Scratchpad array: no reset, only enabled lanes of in-range words update.
  always_ff @(posedge clock) begin
    if (fire && acc_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wr_en[i]) mem[acc_index][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // Request FSM with registered outputs. Outputs default to 0 every cycle so
  // mem_ready is a single pulse and rdata/error read 0 outside responses.
  // A mem_valid seen in WAIT is a protocol violation and is simply dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      count        <= 4'd0;
      cap_index    <= '0;
      cap_in_range <= 1'b0;
      cap_wdata    <= 32'd0;
      cap_wr_en    <= 4'd0;
      mem_ready    <= 1'b0;
      mem_rdata    <= 32'd0;
      mem_error    <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      mem_error <= 1'b0;
      if (fire) begin
        state     <= S_RESP;
        mem_ready <= 1'b1;
        mem_rdata <= acc_in_range ? merged_word : 32'd0;
        mem_error <= !acc_in_range;
      end else if (accept) begin
        state        <= S_WAIT;
        count        <= WAIT_LOAD;
        cap_index    <= req_index;
        cap_in_range <= req_in_range;
        cap_wdata    <= mem_wdata;
        cap_wr_en    <= req_wr_en;
      end else if (state == S_WAIT) begin
        count <= count - 4'd1;
      end else begin
        state <= S_IDLE;
      end
    end
  end

endmodule
